mat_operand_feeder: RTL and testbench

- Upstream stage of the 3x3 Q4.4 matrix multiplier.
- Accepts one byte-serial load frame holding matrix A, then matrix B, both row-major, and stores both matrices locally.
- Streams A column-by-column on the A port and B row-by-row on the B port. The multiplier pulls each byte with its read strobe.
- After both matrices are fully consumed, returns to LOAD for the next frame.

---
 rtl/mat_operand_feeder.sv | 179 +++++++++++++++++
 tb/tb_mat_operand_feeder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_operand_feeder.sv
// Purpose : buffers one byte-serial frame (A then B, row-major) and streams A
//           column-major on the A port and B row-major on the B port.
// Latency : first A/B element valid 1 cycle after the final load byte.
// Backpressure: o_ld_ready is low outside LOAD, so upstream holds its bytes;
//           each stream element is held until its read strobe consumes it.
// Ports   : i_clk/i_rst_n (sync, active-low); i_ld_* load byte stream with
//           o_ld_ready; o_a_num*/i_a_read and o_b_num*/i_b_read element
//           streams; o_busy (STREAM), o_frame_done (1-cycle pulse),
//           o_ld_err (sticky framing error).
// Option  : define MAT_FEEDER_REPLAY_EN to add i_replay, which re-streams the
//           stored matrices at completion instead of returning to LOAD.
module mat_operand_feeder #(
    parameter int DATA_W = 8,
    parameter int DIM    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_valid,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic [DATA_W-1:0] o_a_num,
    output logic              o_a_num_valid,
    input  logic              i_a_read,
    output logic [DATA_W-1:0] o_b_num,
    output logic              o_b_num_valid,
    input  logic              i_b_read,
`ifdef MAT_FEEDER_REPLAY_EN
    input  logic              i_replay,
`endif
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_ld_err
);

    localparam int N  = DIM * DIM;
    localparam int CW = $clog2(2 * N);
    localparam int IW = $clog2(N + 1);
    localparam int AW = $clog2(2 * N);

    localparam logic [CW-1:0] LD_FINAL = CW'(2 * N - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(N);

    typedef enum logic {
        S_LOAD   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_mem [0:2*N-1];
    logic [CW-1:0]     r_ld_cnt;
    logic [IW-1:0]     r_ai;
    logic [IW-1:0]     r_bi;
    logic              r_ld_err;
    logic              r_frame_done;

    logic              w_ld_xfer;
    logic              w_ld_final;
    logic              w_a_xfer;
    logic              w_b_xfer;
    logic [IW-1:0]     w_ai_nxt;
    logic [IW-1:0]     w_bi_nxt;
    logic              w_complete;
    logic              w_replay;
    logic [AW-1:0]     w_a_addr;
    logic [AW-1:0]     w_b_addr;

`ifdef MAT_FEEDER_REPLAY_EN
    assign w_replay = i_replay;
`else
    assign w_replay = 1'b0;
`endif

    // Handshakes
    assign o_ld_ready    = (r_state == S_LOAD);
    assign o_busy        = (r_state == S_STREAM);
    assign o_a_num_valid = (r_state == S_STREAM) && (r_ai != IDX_END);
    assign o_b_num_valid = (r_state == S_STREAM) && (r_bi != IDX_END);

    assign w_ld_xfer  = i_ld_valid && o_ld_ready;
    assign w_ld_final = (r_ld_cnt == LD_FINAL);
    assign w_a_xfer   = i_a_read && o_a_num_valid;
    assign w_b_xfer   = i_b_read && o_b_num_valid;
    assign w_ai_nxt   = r_ai + {{(IW-1){1'b0}}, w_a_xfer};
    assign w_bi_nxt   = r_bi + {{(IW-1){1'b0}}, w_b_xfer};

    // Completes on whichever transfer (or simultaneous pair) drains the last
    // outstanding element of both streams.
    assign w_complete = (r_state == S_STREAM) && (w_a_xfer || w_b_xfer) &&
                        (w_ai_nxt == IDX_END) && (w_bi_nxt == IDX_END);

    // Storage is laid out in load order: A row-major at 0..N-1, B at N..2N-1.
    // A is read column-major, so its index is transposed into the address.
    // The modulo keeps the address in range once an index has reached N.
    always_comb begin
        w_a_addr = AW'(((int'(r_ai) % N) % DIM) * DIM + (int'(r_ai) % N) / DIM);
        w_b_addr = AW'(N + (int'(r_bi) % N));
    end

    assign o_a_num = r_mem[w_a_addr];
    assign o_b_num = r_mem[w_b_addr];

    assign o_frame_done = r_frame_done;
    assign o_ld_err     = r_ld_err;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_ld_xfer && w_ld_final) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_complete && !w_replay) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Element storage has no reset; contents are only read after a full load.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_ld_xfer) begin
            r_mem[r_ld_cnt] <= i_ld_data;
        end
    end

    // Counters and status flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ld_cnt     <= '0;
            r_ai         <= '0;
            r_bi         <= '0;
            r_ld_err     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_complete;

            if (w_ld_xfer) begin
                if (w_ld_final) begin
                    // Frame is accepted even when the last flag is missing.
                    r_ld_cnt <= '0;
                    if (!i_ld_last) begin
                        r_ld_err <= 1'b1;
                    end
                end else if (i_ld_last) begin
                    // Short frame: discard what was collected and restart.
                    r_ld_cnt <= '0;
                    r_ld_err <= 1'b1;
                end else begin
                    r_ld_cnt <= r_ld_cnt + 1'b1;
                end
            end

            if (w_complete) begin
                r_ai <= '0;
                r_bi <= '0;
            end else begin
                r_ai <= w_ai_nxt;
                r_bi <= w_bi_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mat_operand_feeder.sv
module tb_mat_operand_feeder;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_ld_data;
    logic       i_ld_valid;
    logic       i_ld_last;
    logic       o_ld_ready;
    logic [7:0] o_a_num;
    logic       o_a_num_valid;
    logic       i_a_read;
    logic [7:0] o_b_num;
    logic       o_b_num_valid;
    logic       i_b_read;
`ifdef MAT_FEEDER_REPLAY_EN
    logic       i_replay;
`endif
    logic       o_busy;
    logic       o_frame_done;
    logic       o_ld_err;

    int n_asserts;
    int n_fails;

    mat_operand_feeder #(.DATA_W(8), .DIM(3)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_ld_data     (i_ld_data),
        .i_ld_valid    (i_ld_valid),
        .i_ld_last     (i_ld_last),
        .o_ld_ready    (o_ld_ready),
        .o_a_num       (o_a_num),
        .o_a_num_valid (o_a_num_valid),
        .i_a_read      (i_a_read),
        .o_b_num       (o_b_num),
        .o_b_num_valid (o_b_num_valid),
        .i_b_read      (i_b_read),
`ifdef MAT_FEEDER_REPLAY_EN
        .i_replay      (i_replay),
`endif
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_ld_err      (o_ld_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected A element at stream index ai for a frame of bytes base..base+17:
    // A[r][c] = base + 3r + c, streamed column-major (r = ai%3, c = ai/3).
    function automatic logic [7:0] exp_a(input logic [7:0] base, input int ai);
        return base + 8'(3 * (ai % 3) + ai / 3);
    endfunction

    function automatic logic [7:0] exp_b(input logic [7:0] base, input int bi);
        return base + 8'(9 + bi);
    endfunction

    // Drive n bytes base, base+1, ... with i_ld_last on byte index last_pos.
    task automatic load_bytes(input logic [7:0] base, input int n, input int last_pos);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            n_asserts++;
            if (o_ld_ready !== 1'b1) begin
                n_fails++;
                $display("FAIL load_ready byte %0d: got %b want 1", i, o_ld_ready);
            end
            i_ld_valid = 1'b1;
            i_ld_data  = base + 8'(i);
            i_ld_last  = (i == last_pos);
        end
        @(negedge i_clk);
        i_ld_valid = 1'b0;
        i_ld_last  = 1'b0;
    endtask

    // Stream a full frame with both read strobes held high, so the last A and
    // last B transfer in the same cycle. Starts at the negedge after loading.
    task automatic stream_all(input logic [7:0] base, input bit replay_exp);
        for (int k = 0; k < 9; k++) begin
            n_asserts++;
            if (o_a_num_valid !== 1'b1 || o_a_num !== exp_a(base, k)) begin
                n_fails++;
                $display("FAIL stream_a[%0d]: got v=%b %h want v=1 %h",
                         k, o_a_num_valid, o_a_num, exp_a(base, k));
            end
            n_asserts++;
            if (o_b_num_valid !== 1'b1 || o_b_num !== exp_b(base, k)) begin
                n_fails++;
                $display("FAIL stream_b[%0d]: got v=%b %h want v=1 %h",
                         k, o_b_num_valid, o_b_num, exp_b(base, k));
            end
            n_asserts++;
            if (o_busy !== 1'b1 || o_ld_ready !== 1'b0 || o_frame_done !== 1'b0) begin
                n_fails++;
                $display("FAIL stream_status[%0d]: got busy=%b rdy=%b done=%b want 1 0 0",
                         k, o_busy, o_ld_ready, o_frame_done);
            end
            i_a_read = 1'b1;
            i_b_read = 1'b1;
            @(negedge i_clk);
        end
        i_a_read = 1'b0;
        i_b_read = 1'b0;
        n_asserts++;
        if (o_frame_done !== 1'b1) begin
            n_fails++;
            $display("FAIL frame_done_pulse: got %b want 1", o_frame_done);
        end
        n_asserts++;
        if (replay_exp) begin
            if (o_busy !== 1'b1 || o_ld_ready !== 1'b0 || o_a_num !== exp_a(base, 0)) begin
                n_fails++;
                $display("FAIL replay_state: got busy=%b rdy=%b a=%h want 1 0 %h",
                         o_busy, o_ld_ready, o_a_num, exp_a(base, 0));
            end
        end else begin
            if (o_busy !== 1'b0 || o_ld_ready !== 1'b1 || o_a_num_valid !== 1'b0) begin
                n_fails++;
                $display("FAIL return_to_load: got busy=%b rdy=%b av=%b want 0 1 0",
                         o_busy, o_ld_ready, o_a_num_valid);
            end
        end
        if (!replay_exp) begin
            @(negedge i_clk);
            n_asserts++;
            if (o_frame_done !== 1'b0) begin
                n_fails++;
                $display("FAIL frame_done_single: got %b want 0", o_frame_done);
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_ld_data = 8'h00; i_ld_valid = 1'b0; i_ld_last = 1'b0;
        i_a_read = 1'b0; i_b_read = 1'b0;
`ifdef MAT_FEEDER_REPLAY_EN
        i_replay = 1'b0;
`endif
        repeat (3) @(negedge i_clk);
        n_asserts++;
        if (o_ld_ready !== 1'b1 || o_busy !== 1'b0 || o_a_num_valid !== 1'b0 ||
            o_b_num_valid !== 1'b0 || o_frame_done !== 1'b0 || o_ld_err !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_values: got rdy=%b busy=%b av=%b bv=%b done=%b err=%b want 1 0 0 0 0 0",
                     o_ld_ready, o_busy, o_a_num_valid, o_b_num_valid, o_frame_done, o_ld_err);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_basic_stream();
        load_bytes(8'h01, 18, 17);
        stream_all(8'h01, 1'b0);
        n_asserts++;
        if (o_ld_err !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_ld_err: got %b want 0", o_ld_err);
        end
    endtask

    task automatic test_throttle();
        int ea;
        int cyc;
        load_bytes(8'h20, 18, 17);
        ea  = 0;
        cyc = 0;
        // Load bytes offered during STREAM must not be accepted.
        i_ld_valid = 1'b1;
        i_ld_data  = 8'hEE;
        while (ea < 9 && cyc < 40) begin
            n_asserts++;
            if (o_a_num_valid !== 1'b1 || o_a_num !== exp_a(8'h20, ea)) begin
                n_fails++;
                $display("FAIL throttle_a[%0d]: got v=%b %h want v=1 %h",
                         ea, o_a_num_valid, o_a_num, exp_a(8'h20, ea));
            end
            n_asserts++;
            if (o_b_num_valid !== 1'b1 || o_b_num !== 8'h29 || o_ld_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL throttle_b_hold: got v=%b %h rdy=%b want v=1 29 rdy=0",
                         o_b_num_valid, o_b_num, o_ld_ready);
            end
            i_a_read = (cyc % 2 == 0);
            i_b_read = 1'b0;
            if (i_a_read) ea++;
            cyc++;
            @(negedge i_clk);
        end
        i_ld_valid = 1'b0;
        n_asserts++;
        if (ea != 9 || o_a_num_valid !== 1'b0 || o_frame_done !== 1'b0 || o_busy !== 1'b1) begin
            n_fails++;
            $display("FAIL throttle_a_done: got ea=%0d av=%b done=%b busy=%b want 9 0 0 1",
                     ea, o_a_num_valid, o_frame_done, o_busy);
        end
        // Hold i_a_read high while A is exhausted: must not disturb the frame.
        for (int j = 0; j < 9; j++) begin
            n_asserts++;
            if (o_b_num_valid !== 1'b1 || o_b_num !== exp_b(8'h20, j) ||
                o_a_num_valid !== 1'b0 || o_frame_done !== 1'b0) begin
                n_fails++;
                $display("FAIL throttle_b[%0d]: got bv=%b %h av=%b done=%b want 1 %h 0 0",
                         j, o_b_num_valid, o_b_num, o_a_num_valid, o_frame_done, exp_b(8'h20, j));
            end
            i_a_read = 1'b1;
            i_b_read = 1'b1;
            @(negedge i_clk);
        end
        i_a_read = 1'b0;
        i_b_read = 1'b0;
        n_asserts++;
        if (o_frame_done !== 1'b1 || o_ld_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL throttle_done: got done=%b rdy=%b want 1 1", o_frame_done, o_ld_ready);
        end
        @(negedge i_clk);
    endtask

    task automatic test_early_last();
        load_bytes(8'h30, 5, 4);
        n_asserts++;
        if (o_ld_err !== 1'b1 || o_ld_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fails++;
            $display("FAIL early_last: got err=%b rdy=%b busy=%b want 1 1 0",
                     o_ld_err, o_ld_ready, o_busy);
        end
        load_bytes(8'h40, 18, 17);
        stream_all(8'h40, 1'b0);
        n_asserts++;
        if (o_ld_err !== 1'b1) begin
            n_fails++;
            $display("FAIL early_last_sticky: got %b want 1", o_ld_err);
        end
    endtask

    task automatic test_reset_mid_stream();
        load_bytes(8'h60, 18, 17);
        for (int k = 0; k < 4; k++) begin
            i_a_read = 1'b1;
            @(negedge i_clk);
        end
        i_a_read = 1'b0;
        n_asserts++;
        if (o_a_num !== exp_a(8'h60, 4)) begin
            n_fails++;
            $display("FAIL mid_a4: got %h want %h", o_a_num, exp_a(8'h60, 4));
        end
        i_rst_n = 1'b0;
        @(negedge i_clk);
        n_asserts++;
        if (o_busy !== 1'b0 || o_a_num_valid !== 1'b0 || o_ld_ready !== 1'b1 || o_ld_err !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_reset: got busy=%b av=%b rdy=%b err=%b want 0 0 1 0",
                     o_busy, o_a_num_valid, o_ld_ready, o_ld_err);
        end
        i_rst_n = 1'b1;
        // Reload without i_ld_last: the frame proceeds but flags an error.
        load_bytes(8'h70, 18, 99);
        n_asserts++;
        if (o_ld_err !== 1'b1) begin
            n_fails++;
            $display("FAIL missing_last_err: got %b want 1", o_ld_err);
        end
        stream_all(8'h70, 1'b0);
    endtask

`ifdef MAT_FEEDER_REPLAY_EN
    task automatic test_replay();
        load_bytes(8'h80, 18, 17);
        i_replay = 1'b1;
        stream_all(8'h80, 1'b1);
        i_replay = 1'b0;
        stream_all(8'h80, 1'b0);
    endtask
`endif

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        test_reset();
        test_basic_stream();
        test_throttle();
        test_early_last();
        test_reset_mid_stream();
`ifdef MAT_FEEDER_REPLAY_EN
        test_replay();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
